// File: rtl/fifo_fwft_stream_adapter.sv
// FWFT valid/ready stream adapter for the read port of a single-clock FIFO.
// Keeps a small circular buffer so reads can be issued ahead of consumer demand.
module fifo_fwft_stream_adapter #(
    parameter int DATA_WIDTH = 36,
    parameter int RD_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FIFO_EMPTY,
    input  logic                  FIFO_UNDERFLOW,
    output logic                  FIFO_RDEN,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    input  logic                  ERR_CLR,
    output logic                  ERR_UNDERFLOW,
    output logic [1:0]            OCCUPANCY
);

    localparam int DEPTH = RD_LATENCY + 1;
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [1:0] DEPTH2 = 2'(DEPTH);
    localparam logic [2:0] DEPTH3 = 3'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic                  rden;
    logic                  capture;
    logic [1:0]            n_inflight;
    logic [2:0]            demand;

    // Pointers wrap explicitly so a depth of 3 needs no power-of-2 rounding.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_latency
        // Only elaborated for an unsupported read latency.
        initial begin
            $error("fifo_fwft_stream_adapter: RD_LATENCY must be 1 or 2");
            $finish;
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        // Word arrives at the edge that retires the read: nothing waits in flight.
        assign capture    = rden;
        assign n_inflight = 2'd0;
    end else begin : g_latn
        logic [RD_LATENCY-2:0] inflight_q, inflight_d;

        // Shift issued reads toward the capture point.
        always_comb begin
            inflight_d    = inflight_q << 1;
            inflight_d[0] = rden;
        end

        // In-flight read tracker.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) inflight_q <= '0;
            else       inflight_q <= inflight_d;
        end

        // Count of reads issued but not yet captured.
        always_comb begin
            n_inflight = 2'd0;
            for (int i = 0; i < RD_LATENCY - 1; i++)
                n_inflight = n_inflight + {1'b0, inflight_q[i]};
        end

        assign capture = inflight_q[RD_LATENCY-2];
    end

    assign M_VALID       = (occ_q != 2'd0);
    assign M_DATA        = mem_q[head_q];
    assign OCCUPANCY     = occ_q;
    assign ERR_UNDERFLOW = err_q;
    assign xfer          = M_VALID & M_READY;

    // Issue a read only when a slot is certain to be free on its return;
    // M_READY feeds this path so a draining word frees its slot at once.
    always_comb begin
        demand = {1'b0, occ_q} + {1'b0, n_inflight} - {2'b00, xfer};
        rden   = !RESET && !FIFO_EMPTY && (demand < DEPTH3);
    end

    assign FIFO_RDEN = rden;

    // Next-state for buffer storage, pointers, occupancy and error flag.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        err_d  = err_q;
        if (capture) begin
            mem_d[tail_q] = FIFO_RD_DATA;
            tail_d        = ptr_inc(tail_q);
        end
        if (xfer) head_d = ptr_inc(head_q);
        occ_d = occ_q + {1'b0, capture} - {1'b0, xfer};
        if (ERR_CLR)        err_d = 1'b0;
        if (FIFO_UNDERFLOW) err_d = 1'b1;
    end

    // State registers; reset drops buffered words and clears the error.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
        end
    end

    a_no_overflow: assert property (
        @(posedge CLK) disable iff (RESET)
        !(capture && !xfer && (occ_q == DEPTH2))
    ) else $error("fifo_fwft_stream_adapter: capture into full buffer");

endmodule

// File: tb/tb_fifo_fwft_stream_adapter.sv
// Directed bench for fifo_fwft_stream_adapter, latency 1 and 2 instances.
// A queue models the FIFO read port of each instance.
module tb_fifo_fwft_stream_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst1, empty1, unf1, rden1, valid1, ready1, clr1, err1;
    logic [35:0] rdd1, md1;
    logic [1:0]  occ1;
    logic        rst2, empty2, unf2, rden2, valid2, ready2, clr2, err2;
    logic [35:0] rdd2, md2;
    logic [1:0]  occ2;

    fifo_fwft_stream_adapter #(.DATA_WIDTH(36), .RD_LATENCY(1)) u_l1 (
        .CLK(clk), .RESET(rst1), .FIFO_EMPTY(empty1),
        .FIFO_UNDERFLOW(unf1), .FIFO_RDEN(rden1), .FIFO_RD_DATA(rdd1),
        .M_DATA(md1), .M_VALID(valid1), .M_READY(ready1),
        .ERR_CLR(clr1), .ERR_UNDERFLOW(err1), .OCCUPANCY(occ1)
    );

    fifo_fwft_stream_adapter #(.DATA_WIDTH(36), .RD_LATENCY(2)) u_l2 (
        .CLK(clk), .RESET(rst2), .FIFO_EMPTY(empty2),
        .FIFO_UNDERFLOW(unf2), .FIFO_RDEN(rden2), .FIFO_RD_DATA(rdd2),
        .M_DATA(md2), .M_VALID(valid2), .M_READY(ready2),
        .ERR_CLR(clr2), .ERR_UNDERFLOW(err2), .OCCUPANCY(occ2)
    );

    logic [35:0] fq1[$], fq2[$], got1[$], got2[$];
    int          viol = 0;

    logic        s_rden1, s_valid1, s_err1, s_rden2, s_valid2, s_err2;
    logic [35:0] s_md1, s_md2;
    logic [1:0]  s_occ1, s_occ2;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Latency 1: read data is the FIFO head; latency 2: registered on the read edge.
    task automatic refresh();
        empty1 = (fq1.size() == 0);
        rdd1   = empty1 ? 36'h0 : fq1[0];
        empty2 = (fq2.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        s_rden1 = rden1; s_valid1 = valid1; s_md1 = md1;
        s_occ1 = occ1; s_err1 = err1;
        s_rden2 = rden2; s_valid2 = valid2; s_md2 = md2;
        s_occ2 = occ2; s_err2 = err2;
        if (rden1 && empty1) viol++;
        if (rden2 && empty2) viol++;
        if (valid1 && ready1) got1.push_back(md1);
        if (valid2 && ready2) got2.push_back(md2);
        @(posedge clk);
        #1;
        if (s_rden1 && !rst1 && fq1.size() > 0) void'(fq1.pop_front());
        if (s_rden2 && !rst2 && fq2.size() > 0) rdd2 = fq2.pop_front();
        refresh();
    endtask

    task automatic test_reset();
        rst1 = 1; rst2 = 1;
        unf1 = 0; unf2 = 0; clr1 = 0; clr2 = 0;
        ready1 = 0; ready2 = 0; rdd2 = '0;
        refresh();
        tick(); tick();
        tests++; if (s_valid1 !== 1'b0) begin fails++; $display("FAIL rst_valid1: got %b want 0", s_valid1); end
        tests++; if (s_md1 !== 36'h0) begin fails++; $display("FAIL rst_data1: got %h want 0", s_md1); end
        tests++; if (s_occ1 !== 2'd0) begin fails++; $display("FAIL rst_occ1: got %0d want 0", s_occ1); end
        tests++; if (s_err1 !== 1'b0) begin fails++; $display("FAIL rst_err1: got %b want 0", s_err1); end
        tests++; if (s_rden1 !== 1'b0) begin fails++; $display("FAIL rst_rden1: got %b want 0", s_rden1); end
        tests++; if (s_valid2 !== 1'b0 || s_occ2 !== 2'd0) begin fails++; $display("FAIL rst_inst2: valid %b occ %0d want 0 0", s_valid2, s_occ2); end
        rst1 = 0; rst2 = 0;
        tick();
    endtask

    task automatic test_preload();
        logic       exp_rden [5];
        logic       exp_val  [5];
        logic [35:0] exp_dat [5];
        exp_rden = '{1, 1, 1, 0, 0};
        exp_val  = '{0, 1, 1, 1, 0};
        exp_dat  = '{0, 36'h1, 36'h2, 36'h3, 0};
        got1.delete();
        ready1 = 1;
        fq1.push_back(36'h1); fq1.push_back(36'h2); fq1.push_back(36'h3);
        refresh();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (s_rden1 !== exp_rden[i]) begin
                fails++; $display("FAIL preload_rden c%0d: got %b want %b", i, s_rden1, exp_rden[i]);
            end
            tests++;
            if (s_valid1 !== exp_val[i]) begin
                fails++; $display("FAIL preload_valid c%0d: got %b want %b", i, s_valid1, exp_val[i]);
            end
            if (exp_val[i]) begin
                tests++;
                if (s_md1 !== exp_dat[i]) begin
                    fails++; $display("FAIL preload_data c%0d: got %h want %h", i, s_md1, exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic      exp_rden [5];
        logic [1:0] exp_occ [5];
        int        n;
        exp_rden = '{1, 0, 0, 0, 0};
        exp_occ  = '{1, 2, 2, 2, 2};
        got1.delete();
        ready1 = 1;
        for (int i = 0; i < 8; i++) fq1.push_back(36'h10 + 36'(i));
        refresh();
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            ready1 = 0;
            tick();
            tests++;
            if (s_rden1 !== exp_rden[i]) begin
                fails++; $display("FAIL stall_rden c%0d: got %b want %b", i, s_rden1, exp_rden[i]);
            end
            tests++;
            if (s_occ1 !== exp_occ[i]) begin
                fails++; $display("FAIL stall_occ c%0d: got %0d want %0d", i, s_occ1, exp_occ[i]);
            end
            tests++;
            if (s_valid1 !== 1'b1 || s_md1 !== 36'h12) begin
                fails++; $display("FAIL stall_hold c%0d: valid %b data %h want 1 12", i, s_valid1, s_md1);
            end
        end
        ready1 = 1;
        n = 0;
        while (got1.size() < 8 && n < 40) begin
            tick(); n++;
        end
        tests++;
        if (got1.size() != 8) begin
            fails++; $display("FAIL stall_count: got %0d words want 8", got1.size());
        end
        for (int i = 0; i < got1.size() && i < 8; i++) begin
            tests++;
            if (got1[i] !== 36'h10 + 36'(i)) begin
                fails++; $display("FAIL stall_order w%0d: got %h want %h", i, got1[i], 36'h10 + 36'(i));
            end
        end
    endtask

    task automatic test_lat2();
        int cyc = 0, f_rden = -1, f_val = -1, f_x = -1, l_x = -1, bad = 0;
        logic [1:0] max_occ = 0;
        got2.delete();
        ready2 = 1;
        for (int i = 0; i < 16; i++) fq2.push_back(36'h100 + 36'(i));
        refresh();
        while (got2.size() < 16 && cyc < 60) begin
            tick();
            if (s_rden2 && f_rden < 0) f_rden = cyc;
            if (s_valid2 && f_val < 0) f_val = cyc;
            if (s_valid2) begin
                if (f_x < 0) f_x = cyc;
                l_x = cyc;
            end
            if (s_occ2 > max_occ) max_occ = s_occ2;
            cyc++;
        end
        tests++;
        if (got2.size() != 16) begin
            fails++; $display("FAIL lat2_count: got %0d words want 16", got2.size());
        end
        tests++;
        if (f_val - f_rden != 2) begin
            fails++; $display("FAIL lat2_first: got %0d cycles want 2", f_val - f_rden);
        end
        tests++;
        if (l_x - f_x != 15) begin
            fails++; $display("FAIL lat2_b2b: got span %0d want 15", l_x - f_x);
        end
        tests++;
        if (max_occ > 2'd3) begin
            fails++; $display("FAIL lat2_occ: got %0d want <=3", max_occ);
        end
        for (int i = 0; i < got2.size(); i++)
            if (got2[i] !== 36'h100 + 36'(i)) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL lat2_order: got %0d bad words want 0", bad);
        end
    endtask

    task automatic test_random();
        int s1 = 0, s2 = 0, cyc = 0, bad1 = 0, bad2 = 0;
        got1.delete(); got2.delete();
        viol = 0;
        while ((got1.size() < 1000 || got2.size() < 400) && cyc < 20000) begin
            if (s1 < 1000 && $urandom_range(0, 1) == 1) begin
                fq1.push_back(36'h5_0000_0000 + 36'(s1)); s1++;
            end
            if (s2 < 400 && $urandom_range(0, 1) == 1) begin
                fq2.push_back(36'hA_0000_0000 + 36'(s2)); s2++;
            end
            ready1 = 1'($urandom_range(0, 1));
            ready2 = 1'($urandom_range(0, 1));
            refresh();
            tick();
            cyc++;
        end
        tests++;
        if (got1.size() != 1000 || got2.size() != 400) begin
            fails++; $display("FAIL rand_count: got %0d/%0d want 1000/400", got1.size(), got2.size());
        end
        for (int i = 0; i < got1.size(); i++)
            if (got1[i] !== 36'h5_0000_0000 + 36'(i)) bad1++;
        for (int i = 0; i < got2.size(); i++)
            if (got2[i] !== 36'hA_0000_0000 + 36'(i)) bad2++;
        tests++;
        if (bad1 != 0 || bad2 != 0) begin
            fails++; $display("FAIL rand_order: got %0d/%0d bad words want 0/0", bad1, bad2);
        end
        tests++;
        if (viol != 0) begin
            fails++; $display("FAIL rand_rden_empty: got %0d reads while empty want 0", viol);
        end
        ready1 = 0; ready2 = 0;
        tick();
    endtask

    task automatic test_underflow();
        unf1 = 1; tick(); unf1 = 0; tick();
        tests++; if (s_err1 !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", s_err1); end
        tick();
        tests++; if (s_err1 !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", s_err1); end
        clr1 = 1; tick(); clr1 = 0; tick();
        tests++; if (s_err1 !== 1'b0) begin fails++; $display("FAIL err_clr: got %b want 0", s_err1); end
        unf1 = 1; tick(); unf1 = 0; tick();
        tests++; if (s_err1 !== 1'b1) begin fails++; $display("FAIL err_set2: got %b want 1", s_err1); end
        clr1 = 1; unf1 = 1; tick(); clr1 = 0; unf1 = 0; tick();
        tests++; if (s_err1 !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b want 1", s_err1); end
        clr1 = 1; tick(); clr1 = 0; tick();
        tests++; if (s_err1 !== 1'b0) begin fails++; $display("FAIL err_clr2: got %b want 0", s_err1); end
        tests++; if (s_err2 !== 1'b0) begin fails++; $display("FAIL err_isolated: got %b want 0", s_err2); end
    endtask

    task automatic test_async_reset();
        ready2 = 0;
        for (int i = 0; i < 4; i++) fq2.push_back(36'h200 + 36'(i));
        refresh();
        tick(); tick(); tick();
        #2;
        tests++;
        if (valid2 !== 1'b1 || occ2 !== 2'd2 || rden2 !== 1'b0) begin
            fails++; $display("FAIL ares_pre: valid %b occ %0d rden %b want 1 2 0", valid2, occ2, rden2);
        end
        rst2 = 1;
        #1;
        tests++;
        if (valid2 !== 1'b0 || occ2 !== 2'd0 || rden2 !== 1'b0) begin
            fails++; $display("FAIL ares_now: valid %b occ %0d rden %b want 0 0 0", valid2, occ2, rden2);
        end
        fq2.delete();
        refresh();
        tick(); tick();
        rst2 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (s_valid2 !== 1'b0 || s_occ2 !== 2'd0) begin
                fails++; $display("FAIL ares_after c%0d: valid %b occ %0d want 0 0", i, s_valid2, s_occ2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_backpressure();
        test_lat2();
        test_random();
        test_underflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
